// File: rtl/controle_pipeline_hazard_pkg.sv
// Shared decode constants: opcodes, funct7 values, 4-bit ALU op codes, control bundle.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package ctrl_pkg;

    // Major opcodes (instr[6:0]) handled by the decoder
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // funct7 values that select base, alternate (SUB/SRA) and M-extension ops
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU operation encoding seen by the EX stage
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_SLL   = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SRL   = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;
    localparam logic [3:0] ALU_MULH  = 4'd12;
    localparam logic [3:0] ALU_DIV   = 4'd13;
    localparam logic [3:0] ALU_REM   = 4'd14;

    // Control bundle carried in the ID/EX register
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc;
        logic [3:0] alucontrol;
    } ctrl_t;

    // funct3 -> ALU op for the register and immediate integer groups;
    // alt selects SUB (f3=000) or SRA (f3=101)
    function automatic logic [3:0] base_alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/controle_pipeline_hazard_if.sv
// ID-side inputs and EX-side control outputs of the decode/hazard unit.
// Latency: n/a (wires only).
// Backpressure: stall_o holds the front end; flush_if_id_o kills IF/ID.
interface controle_pipeline_hazard_if;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush_ex;
    logic        stall_o;
    logic        flush_if_id_o;
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic        ex_alusrc;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_jalr;
    logic        ex_auipc;
    logic [3:0]  ex_alucontrol;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_illegal;

    // Pipeline side: supplies the ID instruction and EX redirect, consumes controls
    modport master (
        output id_instr, id_valid, flush_ex,
        input  stall_o, flush_if_id_o, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_branch, ex_jump, ex_jalr, ex_auipc,
               ex_alucontrol, ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_illegal
    );

    // Control unit side
    modport slave (
        input  id_instr, id_valid, flush_ex,
        output stall_o, flush_if_id_o, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_branch, ex_jump, ex_jalr, ex_auipc,
               ex_alucontrol, ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_illegal
    );
endinterface

// File: rtl/controle_pipeline_hazard_decoder.sv
// Combinational RV32I(+M) decoder: control bundle, register usage, multi-cycle class.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; consumers decide whether to use the result.
module controle_decoder
    import ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_mul,
    output logic        is_div,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [6:0] funct7;

    // Raw instruction fields; rd/rs are passed on unmodified for forwarding
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Decode: everything starts illegal with all controls off; each legal
    // pattern switches its own controls on. Illegal encodings read no registers.
    always_comb begin
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        illegal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    illegal         = 1'b0;
                    ctrl.regwrite   = 1'b1;
                    ctrl.alucontrol = base_alu_op(funct3, funct7 == F7_ALT);
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                end else if (M_EXT != 0 && funct7 == F7_MULDIV) begin
                    illegal       = 1'b0;
                    ctrl.regwrite = 1'b1;
                    uses_rs1      = 1'b1;
                    uses_rs2      = 1'b1;
                    is_mul        = ~funct3[2];
                    is_div        = funct3[2];
                    case (funct3)
                        3'b000:                 ctrl.alucontrol = ALU_MUL;
                        3'b001, 3'b010, 3'b011: ctrl.alucontrol = ALU_MULH;
                        3'b100, 3'b101:         ctrl.alucontrol = ALU_DIV;
                        default:                ctrl.alucontrol = ALU_REM;
                    endcase
                end
            end
            OP_IMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; only SRLI/SRAI may set bit 30
                if ((funct3 != 3'b001 && funct3 != 3'b101) ||
                    (funct3 == 3'b001 && funct7 == F7_BASE) ||
                    (funct3 == 3'b101 && (funct7 == F7_BASE || funct7 == F7_ALT))) begin
                    illegal         = 1'b0;
                    ctrl.regwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = base_alu_op(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
                    uses_rs1        = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    illegal         = 1'b0;
                    ctrl.regwrite   = 1'b1;
                    ctrl.memread    = 1'b1;
                    ctrl.memtoreg   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                    uses_rs1        = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3[2] == 1'b0 && funct3 != 3'b011) begin
                    illegal         = 1'b0;
                    ctrl.memwrite   = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    illegal     = 1'b0;
                    ctrl.branch = 1'b1;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                    case (funct3[2:1])
                        2'b00:   ctrl.alucontrol = ALU_SUB;
                        2'b10:   ctrl.alucontrol = ALU_SLT;
                        default: ctrl.alucontrol = ALU_SLTU;
                    endcase
                end
            end
            OP_LUI: begin
                illegal         = 1'b0;
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = ALU_PASSB;
            end
            OP_AUIPC: begin
                illegal         = 1'b0;
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.auipc      = 1'b1;
                ctrl.alucontrol = ALU_ADD;
            end
            OP_JAL: begin
                illegal       = 1'b0;
                ctrl.regwrite = 1'b1;
                ctrl.jump     = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    illegal         = 1'b0;
                    ctrl.regwrite   = 1'b1;
                    ctrl.jalr       = 1'b1;
                    ctrl.alusrc     = 1'b1;
                    ctrl.alucontrol = ALU_ADD;
                    uses_rs1        = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controle_pipeline_hazard.sv
// ID/EX control register with load-use interlock, MUL/DIV busy hold and EX flush.
// Latency: 1 cycle ID->EX; MUL/DIV stay MUL_LAT/DIV_LAT cycles in EX.
// Backpressure: stall_o (combinational) holds PC and IF/ID; flush_ex wins over everything but reset.
module controle_pipeline_hazard
    import ctrl_pkg::*;
#(
    parameter int M_EXT   = 1,
    parameter int MUL_LAT = 2,   // >= 1
    parameter int DIV_LAT = 8,   // >= 1
    parameter int CNT_W   = 4    // 2**CNT_W > max(MUL_LAT, DIV_LAT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    controle_pipeline_hazard_if.slave   bus
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    ctrl_t       dec_ctrl;
    logic [2:0]  dec_funct3;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic        dec_is_mul;
    logic        dec_is_div;
    logic        dec_illegal;

    ctrl_t       ex_ctrl_q;
    logic        ex_valid_q;
    logic        ex_illegal_q;
    logic [2:0]  ex_funct3_q;
    logic [4:0]  ex_rd_q;
    logic [4:0]  ex_rs1_q;
    logic [4:0]  ex_rs2_q;
    logic [CNT_W-1:0] busy_cnt;

    logic        busy;
    logic        load_use;
    logic        load_bubble;

    controle_decoder #(
        .M_EXT (M_EXT)
    ) u_dec (
        .instr    (bus.id_instr),
        .ctrl     (dec_ctrl),
        .funct3   (dec_funct3),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .is_mul   (dec_is_mul),
        .is_div   (dec_is_div),
        .illegal  (dec_illegal)
    );

    // A multi-cycle op still owns EX while the counter is non-zero
    assign busy = (busy_cnt != '0);

    // Load in EX whose destination is a register the ID instruction actually reads
    assign load_use = bus.id_valid & ex_valid_q & ex_ctrl_q.memread & (ex_rd_q != 5'd0) &
                      ((dec_uses_rs1 & (dec_rs1 == ex_rd_q)) |
                       (dec_uses_rs2 & (dec_rs2 == ex_rd_q)));

    // Outside a busy period, a hazard or an empty IF/ID slot inserts a bubble
    assign load_bubble = load_use | ~bus.id_valid;

    // A redirect cancels the hold: the front end must fetch the new target
    assign bus.stall_o       = rst_n & ~bus.flush_ex & (busy | load_use);
    assign bus.flush_if_id_o = rst_n & bus.flush_ex;

    // ID/EX register: reset/flush/hazard insert a bubble, busy holds, otherwise load
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_ex || (!busy && load_bubble)) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_illegal_q <= 1'b0;
            ex_funct3_q  <= 3'd0;
            ex_rd_q      <= 5'd0;
            ex_rs1_q     <= 5'd0;
            ex_rs2_q     <= 5'd0;
        end else if (!busy) begin
            ex_valid_q   <= 1'b1;
            ex_ctrl_q    <= dec_ctrl;
            ex_illegal_q <= dec_illegal;
            ex_funct3_q  <= dec_funct3;
            ex_rd_q      <= dec_rd;
            ex_rs1_q     <= dec_rs1;
            ex_rs2_q     <= dec_rs2;
        end
    end

    // Busy counter: loaded with the extra EX cycles of the op entering EX, counts down
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_ex) begin
            busy_cnt <= '0;
        end else if (busy) begin
            busy_cnt <= busy_cnt - CNT_W'(1);
        end else if (load_bubble) begin
            busy_cnt <= '0;
        end else if (dec_is_mul) begin
            busy_cnt <= MUL_LOAD;
        end else if (dec_is_div) begin
            busy_cnt <= DIV_LOAD;
        end else begin
            busy_cnt <= '0;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_regwrite   = ex_ctrl_q.regwrite;
    assign bus.ex_memread    = ex_ctrl_q.memread;
    assign bus.ex_memwrite   = ex_ctrl_q.memwrite;
    assign bus.ex_memtoreg   = ex_ctrl_q.memtoreg;
    assign bus.ex_alusrc     = ex_ctrl_q.alusrc;
    assign bus.ex_branch     = ex_ctrl_q.branch;
    assign bus.ex_jump       = ex_ctrl_q.jump;
    assign bus.ex_jalr       = ex_ctrl_q.jalr;
    assign bus.ex_auipc      = ex_ctrl_q.auipc;
    assign bus.ex_alucontrol = ex_ctrl_q.alucontrol;
    assign bus.ex_funct3     = ex_funct3_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_rs1        = ex_rs1_q;
    assign bus.ex_rs2        = ex_rs2_q;
    assign bus.ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_controle_pipeline_hazard.sv
// Bench for controle_pipeline_hazard: two DUTs (M_EXT=1 and M_EXT=0) share stimulus.
// Latency: model tracks EX contents and remaining EX residency per DUT.
// Backpressure: the bench front end honours the expected stall of the M_EXT=1 DUT.
module tb_controle_pipeline_hazard;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       auipc;
        logic       illegal;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush_ex;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    controle_pipeline_hazard_if if0();
    controle_pipeline_hazard_if if1();

    assign if0.id_instr = id_instr;
    assign if0.id_valid = id_valid;
    assign if0.flush_ex = flush_ex;
    assign if1.id_instr = id_instr;
    assign if1.id_valid = id_valid;
    assign if1.flush_ex = flush_ex;

    controle_pipeline_hazard #(.M_EXT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    controle_pipeline_hazard #(.M_EXT(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    obs_t obs0, obs1;
    assign obs0 = {if0.ex_valid, if0.ex_regwrite, if0.ex_memread, if0.ex_memwrite, if0.ex_memtoreg,
                   if0.ex_alusrc, if0.ex_branch, if0.ex_jump, if0.ex_jalr, if0.ex_auipc,
                   if0.ex_illegal, if0.ex_alucontrol, if0.ex_funct3, if0.ex_rd, if0.ex_rs1, if0.ex_rs2};
    assign obs1 = {if1.ex_valid, if1.ex_regwrite, if1.ex_memread, if1.ex_memwrite, if1.ex_memtoreg,
                   if1.ex_alusrc, if1.ex_branch, if1.ex_jump, if1.ex_jalr, if1.ex_auipc,
                   if1.ex_illegal, if1.ex_alucontrol, if1.ex_funct3, if1.ex_rd, if1.ex_rs1, if1.ex_rs2};

    // Model state: what EX must hold, how many more cycles it must stay, and this cycle's stall
    obs_t mex[2];
    int   hold[2];
    bit   mstall[2];
    bit   mlu[2];

    // Reference decode by instruction class; lat = total EX cycles of the instruction
    function automatic void ref_dec(input logic [31:0] ins, input bit mext, output obs_t o,
                                    output bit u1, output bit u2, output int lat);
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit ok;
        logic [3:0] rr [8];
        rr = '{4'd2, 4'd3, 4'd7, 4'd8, 4'd4, 4'd5, 4'd1, 4'd0};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        o = '0; u1 = 0; u2 = 0; lat = 1; ok = 0;
        if (op == 7'h33 && f7 == 7'h01) begin
            if (mext) begin
                ok = 1; o.regwrite = 1; u1 = 1; u2 = 1;
                if (f3 == 0)      begin o.alu = 11; lat = MUL_LAT; end
                else if (f3 <= 3) begin o.alu = 12; lat = MUL_LAT; end
                else if (f3 <= 5) begin o.alu = 13; lat = DIV_LAT; end
                else              begin o.alu = 14; lat = DIV_LAT; end
            end
        end else if (op == 7'h33) begin
            if (f7 == 0) begin ok = 1; o.alu = rr[f3]; end
            else if (f7 == 7'h20 && f3 == 0) begin ok = 1; o.alu = 6; end
            else if (f7 == 7'h20 && f3 == 5) begin ok = 1; o.alu = 9; end
            if (ok) begin o.regwrite = 1; u1 = 1; u2 = 1; end
        end else if (op == 7'h13) begin
            if (f3 == 1) ok = (f7 == 0);
            else if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
            else ok = 1;
            o.alu = (f3 == 5 && f7 == 7'h20) ? 4'd9 : rr[f3];
            o.regwrite = 1; o.alusrc = 1; u1 = 1;
        end else if (op == 7'h03) begin
            ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            o.regwrite = 1; o.memread = 1; o.memtoreg = 1; o.alusrc = 1; o.alu = 2; u1 = 1;
        end else if (op == 7'h23) begin
            ok = (f3 <= 2);
            o.memwrite = 1; o.alusrc = 1; o.alu = 2; u1 = 1; u2 = 1;
        end else if (op == 7'h63) begin
            ok = !(f3 == 2 || f3 == 3);
            o.branch = 1; u1 = 1; u2 = 1;
            o.alu = (f3 <= 1) ? 4'd6 : (f3 <= 5) ? 4'd7 : 4'd8;
        end else if (op == 7'h37) begin
            ok = 1; o.regwrite = 1; o.alusrc = 1; o.alu = 10;
        end else if (op == 7'h17) begin
            ok = 1; o.regwrite = 1; o.alusrc = 1; o.auipc = 1; o.alu = 2;
        end else if (op == 7'h6F) begin
            ok = 1; o.regwrite = 1; o.jump = 1;
        end else if (op == 7'h67) begin
            ok = (f3 == 0);
            o.regwrite = 1; o.jalr = 1; o.alusrc = 1; o.alu = 2; u1 = 1;
        end
        if (!ok) begin
            o = '0; o.illegal = 1; u1 = 0; u2 = 0; lat = 1;
        end
        o.valid = 1;
        o.f3 = f3; o.rd = ins[11:7]; o.rs1 = ins[19:15]; o.rs2 = ins[24:20];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Compare both DUTs against the model for the current cycle (inputs already applied)
    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            obs_t d, got;
            bit u1, u2, gs, gf;
            int lat;
            ref_dec(id_instr, k == 0, d, u1, u2, lat);
            mlu[k] = id_valid && mex[k].valid && mex[k].memread && mex[k].rd != 0 &&
                     ((u1 && id_instr[19:15] == mex[k].rd) || (u2 && id_instr[24:20] == mex[k].rd));
            mstall[k] = rst_n && !flush_ex && (hold[k] > 0 || mlu[k]);
            got = (k == 0) ? obs0 : obs1;
            gs  = (k == 0) ? if0.stall_o : if1.stall_o;
            gf  = (k == 0) ? if0.flush_if_id_o : if1.flush_if_id_o;
            chk($sformatf("ex_bus dut%0d", k), 64'(got), 64'(mex[k]));
            chk($sformatf("stall dut%0d", k), 64'(gs), 64'(mstall[k]));
            chk($sformatf("flush_if_id dut%0d", k), 64'(gf), 64'(rst_n && flush_ex));
        end
    endtask

    // Advance the model across the coming rising edge
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            obs_t d;
            bit u1, u2;
            int lat;
            ref_dec(id_instr, k == 0, d, u1, u2, lat);
            if (!rst_n || flush_ex) begin
                mex[k] = '0; hold[k] = 0;
            end else if (hold[k] > 0) begin
                hold[k] = hold[k] - 1;
            end else if (mlu[k] || !id_valid) begin
                mex[k] = '0;
            end else begin
                mex[k] = d; hold[k] = lat - 1;
            end
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic v, input logic fl);
        id_instr = ins; id_valid = v; flush_ex = fl;
        #1;
        compare();
        model_update();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4:0] rreg();
        return 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] gen();
        logic [6:0] hi;
        logic [2:0] f;
        int kind, sel;
        kind = $urandom_range(0, 11);
        sel  = $urandom_range(0, 3);
        hi   = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
        f    = 3'($urandom_range(0, 7));
        case (kind)
            0, 1:    return {12'($urandom), rreg(), f, rreg(), 7'h03};
            2, 3:    return {hi, rreg(), rreg(), f, rreg(), 7'h33};
            4:       return {hi, 5'($urandom), rreg(), f, rreg(), 7'h13};
            5:       return {7'($urandom), rreg(), rreg(), f, 5'($urandom), 7'h23};
            6:       return {7'($urandom), rreg(), rreg(), f, 5'($urandom), 7'h63};
            7:       return {20'($urandom), rreg(), 7'h37};
            8:       return {20'($urandom), rreg(), 7'h17};
            9:       return {20'($urandom), rreg(), 7'h6F};
            10:      return {12'($urandom), rreg(), (sel < 3) ? 3'd0 : f, rreg(), 7'h67};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] ADDI9 = 32'h00100493;  // addi x9,x0,1
    localparam logic [31:0] DIV8  = 32'h0220C433;  // div x8,x1,x2

    initial begin
        logic [31:0] cur;
        logic cv;
        for (int k = 0; k < 2; k++) begin mex[k] = '0; hold[k] = 0; mstall[k] = 0; mlu[k] = 0; end
        rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; flush_ex = 1'b0;
        tick();

        // Reset held for two cycles, then first cycle after release
        apply(32'h00228333, 1, 0);
        chk("rst_valid", 64'(obs0.valid), 0);
        chk("rst_stall", 64'(if0.stall_o), 0);
        tick();
        apply(0, 0, 0); tick();
        rst_n = 1'b1;
        apply(0, 0, 0);
        chk("post_rst_stall", 64'(if0.stall_o), 0);
        chk("post_rst_bus", 64'(obs0), 0);
        tick();

        // Load-use: lw x5 then add x6,x5,x2
        apply(32'h0000A283, 1, 0); tick();
        apply(32'h00228333, 1, 0);
        chk("lu_stall", 64'(if0.stall_o), 1);
        chk("lu_model_stall", 64'(mstall[0]), 1);
        tick();
        apply(32'h00228333, 1, 0);
        chk("lu_bubble_valid", 64'(obs0.valid), 0);
        chk("lu_stall_once", 64'(if0.stall_o), 0);
        tick();
        apply(0, 0, 0);
        chk("lu_add_alu", 64'(obs0.alu), 2);
        chk("lu_add_rd", 64'(obs0.rd), 6);
        chk("lu_add_valid", 64'(obs0.valid), 1);
        tick();

        // Load to x0 never interlocks
        apply(32'h0000A003, 1, 0); tick();
        apply(32'h00200333, 1, 0);
        chk("x0_stall", 64'(if0.stall_o), 0);
        tick();

        // MUL with MUL_LAT=2, and the same word on the M_EXT=0 unit
        apply(32'h022083B3, 1, 0); tick();
        apply(ADDI9, 1, 0);
        chk("mul_stall", 64'(if0.stall_o), 1);
        chk("mul_alu", 64'(obs0.alu), 11);
        chk("mul_rd", 64'(obs0.rd), 7);
        chk("nom_illegal", 64'(obs1.illegal), 1);
        chk("nom_valid", 64'(obs1.valid), 1);
        chk("nom_regwrite", 64'(obs1.regwrite), 0);
        chk("nom_stall", 64'(if1.stall_o), 0);
        tick();
        apply(ADDI9, 1, 0);
        chk("mul_stall_end", 64'(if0.stall_o), 0);
        chk("mul_hold_alu", 64'(obs0.alu), 11);
        chk("mul_hold_rd", 64'(obs0.rd), 7);
        tick();
        apply(0, 0, 0);
        chk("after_mul_rd", 64'(obs0.rd), 9);
        tick();

        // Bubble in IF/ID with a would-be hazard raises nothing
        apply(32'h0000A283, 1, 0); tick();
        apply(32'h00228333, 0, 0);
        chk("idv0_stall", 64'(if0.stall_o), 0);
        tick();

        // DIV, flush in the third busy cycle
        apply(DIV8, 1, 0); tick();
        apply(ADDI9, 1, 0); chk("div_busy1", 64'(if0.stall_o), 1); tick();
        apply(ADDI9, 1, 0); chk("div_busy2", 64'(if0.stall_o), 1); tick();
        apply(ADDI9, 1, 1);
        chk("div_flush_ifid", 64'(if0.flush_if_id_o), 1);
        chk("div_alu", 64'(obs0.alu), 13);
        tick();
        apply(ADDI9, 1, 0);
        chk("div_flushed_valid", 64'(obs0.valid), 0);
        chk("div_flushed_stall", 64'(if0.stall_o), 0);
        tick();

        // SRAI against a load to x2: rs2 field is shamt, not a register
        apply(32'h0000A103, 1, 0); tick();
        apply(32'h40225193, 1, 0);
        chk("srai_nostall", 64'(if0.stall_o), 0);
        tick();
        apply(0, 0, 0);
        chk("srai_alu", 64'(obs0.alu), 9);
        chk("srai_alusrc", 64'(obs0.alusrc), 1);
        chk("srai_regwrite", 64'(obs0.regwrite), 1);
        tick();

        // Reset in the middle of a DIV hold
        apply(DIV8, 1, 0); tick();
        apply(ADDI9, 1, 0); chk("rdiv_busy", 64'(if0.stall_o), 1); tick();
        rst_n = 1'b0;
        apply(ADDI9, 1, 0); chk("rdiv_rst_stall", 64'(if0.stall_o), 0); tick();
        rst_n = 1'b1;
        apply(ADDI9, 1, 0);
        chk("rdiv_after_stall", 64'(if0.stall_o), 0);
        chk("rdiv_after_valid", 64'(obs0.valid), 0);
        tick();

        // Randomized traffic; the front end holds IF/ID while a stall is expected
        cur = 0; cv = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!mstall[0]) begin
                cv  = ($urandom_range(0, 9) != 0);
                cur = gen();
            end
            rst_n = ($urandom_range(0, 199) != 0);
            apply(cur, cv, $urandom_range(0, 19) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
